// File: rtl/prng_pkg.sv
// prng_pkg: shared FSM encoding, reset constants and whitener helpers for the LFSR PRNG.
package prng_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} fsm_t;
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] wide_t;
  function automatic wide_t mask(input int n);
    return {MAX_W{1'b1}} >> (MAX_W - n);
  endfunction
  // x must already be confined to its low n bits
  function automatic wide_t rotl1(input wide_t x, input int n);
    return ((x << 1) | (x >> (n - 1))) & mask(n);
  endfunction
  function automatic wide_t rotr1(input wide_t x, input int n);
    return ((x >> 1) | (x << (n - 1))) & mask(n);
  endfunction
  function automatic wide_t whiten(input wide_t s, input int sw, input int ow);
    return rotl1((s >> (sw - ow)) & mask(ow), ow) ^ rotr1(s & mask(ow), ow);
  endfunction
endpackage

// File: rtl/prng_lfsr_core.sv
// prng_lfsr_core: Fibonacci LFSR state and tap registers with seed/taps loading.
module prng_lfsr_core #(
  parameter int STATE_W = 32,
  parameter logic [STATE_W-1:0] DEFAULT_TAPS = STATE_W'(prng_pkg::DEFAULT_TAPS),
  parameter logic [STATE_W-1:0] DEFAULT_SEED = STATE_W'(prng_pkg::DEFAULT_SEED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic               seed_valid,
  input  logic [STATE_W-1:0] seed_data,
  input  logic               taps_valid,
  input  logic [STATE_W-1:0] taps_data,
  output logic [STATE_W-1:0] next_state
);
  localparam logic [STATE_W-1:0] MSB = {1'b1, {(STATE_W-1){1'b0}}};
  logic [STATE_W-1:0] state, taps;
  assign next_state = {state[STATE_W-2:0], ^(state & taps)};
  // Forcing the top tap keeps the step invertible, so a non-zero state never collapses to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEFAULT_SEED;
      taps  <= DEFAULT_TAPS;
    end else begin
      state <= seed_valid ? (seed_data == '0 ? DEFAULT_SEED : seed_data) : step_en ? next_state : state;
      if (taps_valid) taps <= taps_data | MSB;
    end
  end
endmodule

// File: rtl/prng_lfsr_stream.sv
// prng_lfsr_stream: seedable LFSR PRNG with whitened, decimated valid/ready word output.
// Optional repetition health test enabled by defining PRNG_HEALTH_EN.
module prng_lfsr_stream #(
  parameter int STATE_W = 32,
  parameter int OUT_W = 8,
  parameter logic [STATE_W-1:0] DEFAULT_TAPS = STATE_W'(prng_pkg::DEFAULT_TAPS),
  parameter logic [STATE_W-1:0] DEFAULT_SEED = STATE_W'(prng_pkg::DEFAULT_SEED),
  parameter int STEP_W = 4,
  parameter int REP_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_valid,
  input  logic [STATE_W-1:0] seed_data,
  input  logic               taps_valid,
  input  logic [STATE_W-1:0] taps_data,
  input  logic               run_en,
  input  logic [STEP_W-1:0]  steps,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               health_fail
);
  import prng_pkg::*;
  if (STATE_W < 2*OUT_W || STATE_W < 4 || STATE_W > MAX_W || REP_LIMIT < 1) begin : g_bad_cfg
    $error("prng_lfsr_stream: illegal parameter combination");
  end
  fsm_t fsm;
  logic [STEP_W-1:0] cnt;
  logic [STATE_W-1:0] next_state;
  logic [OUT_W-1:0] w;
  logic accept;
  assign w = OUT_W'(whiten(MAX_W'(next_state), STATE_W, OUT_W));
  assign accept = fsm == HOLD && out_ready && !seed_valid;
  prng_lfsr_core #(
    .STATE_W(STATE_W),
    .DEFAULT_TAPS(DEFAULT_TAPS),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk(clk),
    .rst(rst),
    .step_en(fsm == FILL),
    .seed_valid(seed_valid),
    .seed_data(seed_data),
    .taps_valid(taps_valid),
    .taps_data(taps_data),
    .next_state(next_state)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_valid) begin
      fsm       <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (run_en) begin
          fsm <= FILL;
          cnt <= steps;
        end
        FILL: if (cnt == '0) begin
          out_data  <= w;
          out_valid <= 1'b1;
          fsm       <= HOLD;
        end else begin
          cnt <= cnt - 1'b1;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= run_en ? FILL : IDLE;
          cnt       <= steps;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
`ifdef PRNG_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  logic [OUT_W-1:0] last_word;
  logic [REP_W-1:0] rep_cnt, rep_nxt;
  assign rep_nxt = out_data != last_word ? REP_W'(1) : rep_cnt == REP_W'(REP_LIMIT) ? rep_cnt : rep_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word   <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (seed_valid) begin
      last_word   <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (accept) begin
      last_word <= out_data;
      rep_cnt   <= rep_nxt;
      if (rep_nxt == REP_W'(REP_LIMIT)) health_fail <= 1'b1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_prng_lfsr_stream.sv
// tb_prng_lfsr_stream: directed-vector bench for prng_lfsr_stream with hand-computed expectations.
module tb_prng_lfsr_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid = 1'b0;
  logic [31:0] seed_data = '0;
  logic        taps_valid = 1'b0;
  logic [31:0] taps_data = '0;
  logic        run_en = 1'b0;
  logic [3:0]  steps = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        health_fail;
  int vec = 0;
  int miss = 0;
`ifdef PRNG_HEALTH_EN
  localparam logic HF = 1'b1;
`else
  localparam logic HF = 1'b0;
`endif
  always #5 clk = ~clk;
  prng_lfsr_stream dut (
    .clk(clk),
    .rst(rst),
    .seed_valid(seed_valid),
    .seed_data(seed_data),
    .taps_valid(taps_valid),
    .taps_data(taps_data),
    .run_en(run_en),
    .steps(steps),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .health_fail(health_fail)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic seed(input logic [31:0] s);
    seed_valid = 1'b1;
    seed_data = s;
    tick();
    seed_valid = 1'b0;
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_health", 64'(health_fail), 64'h0);
    chk("rst_state", 64'(dut.u_core.state), 64'h1);
    chk("rst_taps", 64'(dut.u_core.taps), 64'h8020_0003);
    // seed 0xFF, steps=0: word 0x7F two cycles after run_en
    steps = 4'd0;
    out_ready = 1'b1;
    seed(32'h0000_00FF);
    chk("s1_seed", 64'(dut.u_core.state), 64'hFF);
    run_en = 1'b1;
    tick();
    chk("s1_lat1", 64'(out_valid), 64'h0);
    tick();
    chk("s1_valid", 64'(out_valid), 64'h1);
    chk("s1_data", 64'(out_data), 64'h7F);
    chk("s1_state", 64'(dut.u_core.state), 64'h1FE);
    run_en = 1'b0;
    tick();
    chk("s1_hs", 64'(out_valid), 64'h0);
    tick();
    chk("s1_idle", 64'(out_valid), 64'h0);
    chk("s1_idle_state", 64'(dut.u_core.state), 64'h1FE);
    // zero seed replaced by default; run_en drops mid-FILL but the word completes
    seed(32'h0);
    chk("s2_seed", 64'(dut.u_core.state), 64'h1);
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    tick();
    chk("s2_valid", 64'(out_valid), 64'h1);
    chk("s2_data", 64'(out_data), 64'h81);
    chk("s2_state", 64'(dut.u_core.state), 64'h3);
    tick(2);
    chk("s2_stop", 64'(out_valid), 64'h0);
    chk("s2_stop_state", 64'(dut.u_core.state), 64'h3);
    // zero taps stored with MSB forced, concurrent with seed load
    taps_valid = 1'b1;
    taps_data = 32'h0;
    seed(32'h8000_0000);
    taps_valid = 1'b0;
    chk("s3_taps", 64'(dut.u_core.taps), 64'h8000_0000);
    chk("s3_seed", 64'(dut.u_core.state), 64'h8000_0000);
    out_ready = 1'b0;
    run_en = 1'b1;
    tick(2);
    chk("s3_valid", 64'(out_valid), 64'h1);
    chk("s3_data", 64'(out_data), 64'h80);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'h1);
      chk("hold_data", 64'(out_data), 64'h80);
      chk("hold_state", 64'(dut.u_core.state), 64'h1);
    end
    seed(32'h1234_5678);
    run_en = 1'b0;
    chk("discard_valid", 64'(out_valid), 64'h0);
    chk("discard_state", 64'(dut.u_core.state), 64'h1234_5678);
    out_ready = 1'b1;
    tick(2);
    chk("discard_none", 64'(out_valid), 64'h0);
    // steps=3: four state changes per word, five-cycle period
    taps_valid = 1'b1;
    taps_data = 32'h8020_0003;
    seed(32'h0000_00FF);
    taps_valid = 1'b0;
    steps = 4'd3;
    run_en = 1'b1;
    tick();
    chk("d_e1_state", 64'(dut.u_core.state), 64'hFF);
    tick();
    chk("d_e2_state", 64'(dut.u_core.state), 64'h1FE);
    tick();
    chk("d_e3_state", 64'(dut.u_core.state), 64'h3FD);
    tick();
    chk("d_e4_state", 64'(dut.u_core.state), 64'h7FB);
    chk("d_e4_valid", 64'(out_valid), 64'h0);
    tick();
    chk("d_w1_valid", 64'(out_valid), 64'h1);
    chk("d_w1_data", 64'(out_data), 64'h7B);
    chk("d_w1_state", 64'(dut.u_core.state), 64'hFF6);
    tick();
    chk("d_hs_valid", 64'(out_valid), 64'h0);
    chk("d_hs_state", 64'(dut.u_core.state), 64'hFF6);
    tick(3);
    chk("d_e9_valid", 64'(out_valid), 64'h0);
    chk("d_e9_state", 64'(dut.u_core.state), 64'h7FB6);
    tick();
    chk("d_w2_valid", 64'(out_valid), 64'h1);
    chk("d_w2_data", 64'(out_data), 64'hB6);
    chk("d_w2_state", 64'(dut.u_core.state), 64'hFF6D);
    run_en = 1'b0;
    tick(2);
    chk("d_stop", 64'(out_valid), 64'h0);
    // constant all-ones state: every word 0x00, trips the repetition test
    taps_valid = 1'b1;
    taps_data = 32'h0;
    seed(32'hFFFF_FFFF);
    taps_valid = 1'b0;
    steps = 4'd0;
    run_en = 1'b1;
    tick(2);
    chk("h_w1_data", 64'(out_data), 64'h0);
    tick(6);
    chk("h_w4_data", 64'(out_data), 64'h0);
    chk("h_before4", 64'(health_fail), 64'h0);
    tick();
    chk("h_after4", 64'(health_fail), 64'(HF));
    run_en = 1'b0;
    tick(3);
    chk("h_sticky", 64'(health_fail), 64'(HF));
    chk("h_idle", 64'(out_valid), 64'h0);
    seed(32'hFFFF_FFFF);
    chk("h_cleared", 64'(health_fail), 64'h0);
    // asynchronous reset in the middle of FILL
    steps = 4'd5;
    run_en = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    chk("ar_state", 64'(dut.u_core.state), 64'h1);
    chk("ar_taps", 64'(dut.u_core.taps), 64'h8020_0003);
    chk("ar_valid", 64'(out_valid), 64'h0);
    run_en = 1'b0;
    tick();
    rst = 1'b0;
    tick(8);
    chk("ar_no_word", 64'(out_valid), 64'h0);
    chk("ar_data", 64'(out_data), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
